minimig_sram_sequencer: RTL and testbench

//  Downstream timing stage for the chip/slow/fast RAM bridge: turns its level-type, active-low

---
 rtl/minimig_sram_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_minimig_sram_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/minimig_sram_sequencer.sv
// Async-SRAM timing stage: turns level-type bridge strobes into one registered SRAM cycle
// with programmable setup, strobe-width and hold phases, and captures read data.
module minimig_sram_sequencer #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        _we_in,
    input  logic        _oe_in,
    input  logic        _bhe_in,
    input  logic        _ble_in,
    input  logic [22:1] address_in,
    input  logic [15:0] data_in,
    output logic        _sram_ce,
    output logic        _sram_we,
    output logic        _sram_oe,
    output logic        _sram_bhe,
    output logic        _sram_ble,
    output logic [22:1] sram_addr,
    output logic [15:0] sram_dout,
    output logic        sram_doe,
    input  logic [15:0] sram_din,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSetup   = 3'd1;
    localparam logic [2:0] StPulse   = 3'd2;
    localparam logic [2:0] StHold    = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    // A zero-length strobe would underflow the counter, so it is stretched to one cycle.
    localparam int unsigned PulseEff  = (PULSE_CYC == 0) ? 1 : PULSE_CYC;
    localparam logic [3:0]  SetupLoad = 4'((SETUP_CYC == 0) ? 0 : SETUP_CYC - 1);
    localparam logic [3:0]  PulseLoad = 4'(PulseEff - 1);
    localparam logic [3:0]  HoldLoad  = 4'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
    localparam logic        SkipSetup = (SETUP_CYC == 0);
    localparam logic        SkipHold  = (HOLD_CYC == 0);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic        ce_n_q, ce_n_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic        bhe_n_q, bhe_n_d;
    logic        ble_n_q, ble_n_d;
    logic [22:1] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        doe_q, doe_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic req;
    logic wr_req;

    assign req    = ~_we_in | ~_oe_in;
    assign wr_req = ~_we_in;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        ce_n_d     = ce_n_q;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;
        bhe_n_d    = bhe_n_q;
        ble_n_d    = ble_n_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        doe_d      = doe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = address_in;
                    dout_d  = data_in;
                    bhe_n_d = _bhe_in;
                    ble_n_d = _ble_in;
                    dir_d   = wr_req;
                    ce_n_d  = 1'b0;
                    doe_d   = wr_req;
                    if (SkipSetup) begin
                        state_d = StPulse;
                        cnt_d   = PulseLoad;
                        we_n_d  = ~wr_req;
                        oe_n_d  = wr_req;
                    end else begin
                        state_d = StSetup;
                        cnt_d   = SetupLoad;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == 4'd0) begin
                    state_d = StPulse;
                    cnt_d   = PulseLoad;
                    we_n_d  = ~dir_q;
                    oe_n_d  = dir_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StPulse: begin
                if (cnt_q == 4'd0) begin
                    we_n_d = 1'b1;
                    oe_n_d = 1'b1;
                    if (!dir_q) begin
                        rd_data_d  = sram_din;
                        rd_valid_d = 1'b1;
                    end
                    if (SkipHold) begin
                        state_d = StRelease;
                        ce_n_d  = 1'b1;
                        doe_d   = 1'b0;
                        bhe_n_d = 1'b1;
                        ble_n_d = 1'b1;
                    end else begin
                        state_d = StHold;
                        cnt_d   = HoldLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRelease;
                    ce_n_d  = 1'b1;
                    doe_d   = 1'b0;
                    bhe_n_d = 1'b1;
                    ble_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRelease: begin
                // Wait for the bridge to drop its level strobe so one access is one cycle.
                if (!req) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                ce_n_d  = 1'b1;
                we_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                doe_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            dir_q      <= 1'b0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            bhe_n_q    <= 1'b1;
            ble_n_q    <= 1'b1;
            addr_q     <= '0;
            dout_q     <= '0;
            doe_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            bhe_n_q    <= bhe_n_d;
            ble_n_q    <= ble_n_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            doe_q      <= doe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign _sram_ce  = ce_n_q;
    assign _sram_we  = we_n_q;
    assign _sram_oe  = oe_n_q;
    assign _sram_bhe = bhe_n_q;
    assign _sram_ble = ble_n_q;
    assign sram_addr = addr_q;
    assign sram_dout = dout_q;
    assign sram_doe  = doe_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_minimig_sram_sequencer.sv
// Bench: two sequencers (default timing and SETUP=0/PULSE=3/HOLD=0) share one stimulus stream
// and are compared each cycle against a timeline model counting cycles since request accept.
module tb_minimig_sram_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we_n, oe_n, bhe_n, ble_n;
    logic [22:1] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    bit          rand_din;

    logic        ce_o [2];
    logic        we_o [2];
    logic        oe_o [2];
    logic        bhe_o [2];
    logic        ble_o [2];
    logic [22:1] addr_o [2];
    logic [15:0] dout_o [2];
    logic        doe_o [2];
    logic [15:0] rd_o [2];
    logic        rv_o [2];
    logic        busy_o [2];

    always #5 clk = ~clk;

    minimig_sram_sequencer u_dut0 (
        .clk(clk), ._reset(reset_n), ._we_in(we_n), ._oe_in(oe_n), ._bhe_in(bhe_n),
        ._ble_in(ble_n), .address_in(addr), .data_in(wdata),
        ._sram_ce(ce_o[0]), ._sram_we(we_o[0]), ._sram_oe(oe_o[0]), ._sram_bhe(bhe_o[0]),
        ._sram_ble(ble_o[0]), .sram_addr(addr_o[0]), .sram_dout(dout_o[0]),
        .sram_doe(doe_o[0]), .sram_din(din), .rd_data(rd_o[0]), .rd_valid(rv_o[0]),
        .busy(busy_o[0])
    );

    minimig_sram_sequencer #(.SETUP_CYC(0), .PULSE_CYC(3), .HOLD_CYC(0)) u_dut1 (
        .clk(clk), ._reset(reset_n), ._we_in(we_n), ._oe_in(oe_n), ._bhe_in(bhe_n),
        ._ble_in(ble_n), .address_in(addr), .data_in(wdata),
        ._sram_ce(ce_o[1]), ._sram_we(we_o[1]), ._sram_oe(oe_o[1]), ._sram_bhe(bhe_o[1]),
        ._sram_ble(ble_o[1]), .sram_addr(addr_o[1]), .sram_dout(dout_o[1]),
        .sram_doe(doe_o[1]), .sram_din(din), .rd_data(rd_o[1]), .rd_valid(rv_o[1]),
        .busy(busy_o[1])
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Phase lengths per instance
    int m_s [2];
    int m_p [2];
    int m_h [2];

    // Model: busy flag plus t = cycles elapsed since the accepting edge
    bit          m_busy [2];
    int          m_t [2];
    bit          m_wr [2];
    logic [22:1] m_addr [2];
    logic [15:0] m_data [2];
    logic        m_bhe [2];
    logic        m_ble [2];
    logic [15:0] m_rd [2];
    bit          m_rv [2];

    int n_ce [2];
    int n_we [2];
    int n_oe [2];
    int n_rv [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_busy[k] = 1'b0;
        m_t[k]    = 0;
        m_wr[k]   = 1'b0;
        m_addr[k] = '0;
        m_data[k] = '0;
        m_bhe[k]  = 1'b1;
        m_ble[k]  = 1'b1;
        m_rd[k]   = '0;
        m_rv[k]   = 1'b0;
    endtask

    task automatic model_edge(input int k);
        int len;
        bit req;
        len      = m_s[k] + m_p[k] + m_h[k];
        req      = !we_n || !oe_n;
        m_rv[k]  = 1'b0;
        if (!m_busy[k]) begin
            if (req) begin
                m_busy[k] = 1'b1;
                m_t[k]    = 1;
                m_wr[k]   = !we_n;
                m_addr[k] = addr;
                m_data[k] = wdata;
                m_bhe[k]  = bhe_n;
                m_ble[k]  = ble_n;
            end
        end else if (m_t[k] <= len) begin
            if (m_t[k] == m_s[k] + m_p[k] && !m_wr[k]) begin
                m_rd[k] = din;
                m_rv[k] = 1'b1;
            end
            m_t[k]++;
        end else if (!req) begin
            m_busy[k] = 1'b0;
        end
    endtask

    task automatic check_outputs(input int k);
        int len;
        bit act, pulse;
        len   = m_s[k] + m_p[k] + m_h[k];
        act   = m_busy[k] && m_t[k] <= len;
        pulse = m_busy[k] && m_t[k] >= m_s[k] + 1 && m_t[k] <= m_s[k] + m_p[k];
        check_eq($sformatf("ce%0d", k), ce_o[k], !act);
        check_eq($sformatf("we%0d", k), we_o[k], !(pulse && m_wr[k]));
        check_eq($sformatf("oe%0d", k), oe_o[k], !(pulse && !m_wr[k]));
        check_eq($sformatf("doe%0d", k), doe_o[k], act && m_wr[k]);
        check_eq($sformatf("busy%0d", k), busy_o[k], m_busy[k]);
        check_eq($sformatf("rv%0d", k), rv_o[k], m_rv[k]);
        check_eq($sformatf("rd%0d", k), rd_o[k], m_rd[k]);
        check_eq($sformatf("addr%0d", k), addr_o[k], m_addr[k]);
        check_eq($sformatf("dout%0d", k), dout_o[k], m_data[k]);
        if (act) begin
            check_eq($sformatf("bhe%0d", k), bhe_o[k], m_bhe[k]);
            check_eq($sformatf("ble%0d", k), ble_o[k], m_ble[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) model_reset(k);
            else model_edge(k);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_outputs(k);
            n_ce[k] += int'(!ce_o[k]);
            n_we[k] += int'(!we_o[k]);
            n_oe[k] += int'(!oe_o[k]);
            n_rv[k] += int'(rv_o[k]);
        end
        if (rand_din) din = 16'($urandom);
    endtask

    // kind: 0 none, 1 write, 2 read, 3 both
    task automatic set_req(input int kind);
        we_n = !(kind == 1 || kind == 3);
        oe_n = !(kind == 2 || kind == 3);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            n_ce[k] = 0;
            n_we[k] = 0;
            n_oe[k] = 0;
            n_rv[k] = 0;
        end
    endtask

    task automatic hold_req(input int kind, input int n);
        set_req(kind);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int guard;
        m_s[0] = 1; m_p[0] = 2; m_h[0] = 1;
        m_s[1] = 0; m_p[1] = 3; m_h[1] = 0;
        reset_n  = 1'b0;
        rand_din = 1'b1;
        set_req(0);
        bhe_n = 1'b1;
        ble_n = 1'b1;
        addr  = '0;
        wdata = '0;
        din   = '0;
        for (int k = 0; k < 2; k++) model_reset(k);
        clear_counts();
        step();
        step();
        reset_n = 1'b1;
        hold_req(0, 3);

        // Directed write: upper byte only
        addr = 22'h12345; wdata = 16'hA55A; bhe_n = 1'b0; ble_n = 1'b1;
        clear_counts();
        hold_req(1, 10);
        hold_req(0, 3);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("wr_ce_len%0d", k), n_ce[k], m_s[k] + m_p[k] + m_h[k]);
            check_eq($sformatf("wr_we_len%0d", k), n_we[k], m_p[k]);
            check_eq($sformatf("wr_addr%0d", k), addr_o[k], 22'h12345);
            check_eq($sformatf("wr_dout%0d", k), dout_o[k], 16'hA55A);
        end

        // Directed read, level held for 20 clocks, then a second access
        rand_din = 1'b0;
        din = 16'h1234;
        clear_counts();
        hold_req(2, 20);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rd_pulses%0d", k), n_rv[k], 1);
            check_eq($sformatf("rd_word%0d", k), rd_o[k], 16'h1234);
            check_eq($sformatf("rd_we_low%0d", k), n_we[k], 0);
            check_eq($sformatf("rd_oe_len%0d", k), n_oe[k], m_p[k]);
        end
        din = 16'hBEEF;
        clear_counts();
        hold_req(0, 1);
        hold_req(2, 10);
        hold_req(0, 2);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rd2_pulses%0d", k), n_rv[k], 1);
            check_eq($sformatf("rd2_word%0d", k), rd_o[k], 16'hBEEF);
        end
        rand_din = 1'b1;

        // Both strobes low: write wins
        clear_counts();
        hold_req(3, 10);
        hold_req(0, 2);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("both_rv%0d", k), n_rv[k], 0);
            check_eq($sformatf("both_oe%0d", k), n_oe[k], 0);
            check_eq($sformatf("both_we%0d", k), n_we[k], m_p[k]);
        end

        // Asynchronous reset in the middle of a write strobe
        set_req(1);
        guard = 0;
        while (!(m_busy[0] && m_t[0] == 2) && guard < 10) begin
            step();
            guard++;
        end
        check_eq("rst_reach_pulse", guard < 10, 1'b1);
        check_eq("rst_pre_we0", we_o[0], 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_ce%0d", k), ce_o[k], 1'b1);
            check_eq($sformatf("rst_we%0d", k), we_o[k], 1'b1);
            check_eq($sformatf("rst_oe%0d", k), oe_o[k], 1'b1);
            check_eq($sformatf("rst_doe%0d", k), doe_o[k], 1'b0);
            check_eq($sformatf("rst_busy%0d", k), busy_o[k], 1'b0);
            check_eq($sformatf("rst_addr%0d", k), addr_o[k], 22'h0);
            model_reset(k);
        end
        set_req(0);
        step();
        reset_n = 1'b1;
        hold_req(0, 2);

        // Randomized traffic with level-held requests and busy input buses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) set_req(int'($urandom_range(0, 3)));
            addr  = 22'($urandom);
            wdata = 16'($urandom);
            bhe_n = 1'($urandom);
            ble_n = 1'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
